dot_product_feeder: RTL and testbench

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

---
 rtl/dot_product_feeder_if.sv | 33 +++
 rtl/dot_product_feeder.sv | 131 +++++++++++++
 tb/tb_dot_product_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_feeder_if.sv
// rtl/dot_product_feeder_if.sv - element write, run control and dot-product unit handshake bundle
interface dot_product_feeder_if #(
  parameter int AW = 8,
  parameter int NI = 8
);
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       result;
  logic              timeout_err;
  logic              dp_reset;
  logic              read_now;
  logic [32*NI-1:0]  first_row_output;
  logic [32*NI-1:0]  second_row_output;
  logic              dp_finish;
  logic [31:0]       dp_result;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, dp_finish, dp_result,
    output busy, done, result, timeout_err, dp_reset, read_now,
           first_row_output, second_row_output
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, dp_finish, dp_result,
    input  busy, done, result, timeout_err, dp_reset, read_now,
           first_row_output, second_row_output
  );
endinterface

// File: rtl/dot_product_feeder.sv
// rtl/dot_product_feeder.sv - buffers two rows, streams them as NI-lane packages, collects the result
// Indices at or beyond NOE are never stored; they read back as zero padding.
module dot_product_feeder #(
  parameter int NOE = 10,
  parameter int NI  = 8,
  parameter int AW  = 8,
  parameter int TMO = 256
) (
  input  logic               clk,
  input  logic               reset,
  dot_product_feeder_if.slave bus
);
  localparam int TOTAL = NOE + NI - (NOE % NI);
  localparam int P     = TOTAL / NI;
  localparam int SW    = $clog2(2 * P);
  localparam int CW    = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] send_cnt_q, send_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   result_q, result_d;
  logic          timeout_err_q, timeout_err_d;

  logic [31:0]   first_buf_q  [NOE];
  logic [31:0]   second_buf_q [NOE];
  logic          wr_ok;
  int            wr_idx;
  logic [32*NI-1:0] first_pkg, second_pkg;

  assign wr_idx = int'(bus.wr_addr);
  assign wr_ok  = bus.wr_en && (state_q == S_IDLE) && (wr_idx < NOE);

  // Buffers are deliberately outside the reset domain so data survives an aborted run.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NOE; j++) begin
      if (wr_ok && wr_idx == j) begin
        if (bus.wr_sel) second_buf_q[j] <= bus.wr_data;
        else            first_buf_q[j]  <= bus.wr_data;
      end
    end
  end

  always_comb begin
    int base;
    first_pkg  = '0;
    second_pkg = '0;
    base = int'(send_cnt_q >> 1) * NI;
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < NOE; j++) begin
        if (base + i == j) begin
          first_pkg[32*(NI-i)-1 -: 32]  = first_buf_q[j];
          second_pkg[32*(NI-i)-1 -: 32] = second_buf_q[j];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    send_cnt_d    = send_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_CLEAR;
          timeout_err_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d    = S_SEND;
        send_cnt_d = '0;
      end
      S_SEND: begin
        if (send_cnt_q == SW'(2 * P - 1)) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          send_cnt_d = send_cnt_q + SW'(1);
        end
      end
      S_WAIT: begin
        // Finish is tested first so it beats a timeout landing on the same cycle.
        if (bus.dp_finish) begin
          result_d = bus.dp_result;
          state_d  = S_DONE;
        end else if (wait_cnt_q == CW'(TMO - 1)) begin
          timeout_err_d = 1'b1;
          result_d      = '0;
          state_d       = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      send_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      send_cnt_q    <= send_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = (state_q == S_DONE);
  assign bus.dp_reset          = (state_q == S_CLEAR);
  assign bus.read_now          = (state_q == S_SEND);
  assign bus.result            = result_q;
  assign bus.timeout_err       = timeout_err_q;
  assign bus.first_row_output  = (state_q == S_SEND) ? first_pkg  : '0;
  assign bus.second_row_output = (state_q == S_SEND) ? second_pkg : '0;
endmodule

// File: tb/tb_dot_product_feeder.sv
// tb/tb_dot_product_feeder.sv - table, hand-sequence and random checks of dot_product_feeder
module tb_dot_product_feeder;
  localparam int NOE   = 10;
  localparam int NI    = 8;
  localparam int AW    = 8;
  localparam int TMO   = 256;
  localparam int TOTAL = NOE + NI - (NOE % NI);
  localparam int P     = TOTAL / NI;
  localparam int PW    = 32 * NI;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_product_feeder_if #(.AW(AW), .NI(NI)) bus ();
  dot_product_feeder #(.NOE(NOE), .NI(NI), .AW(AW), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] m_first  [NOE];
  logic [31:0] m_second [NOE];
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          fin_at;
    logic [31:0] dres;
    bit          early;
    bit          poke;
    logic [31:0] exp_res;
    bit          exp_to;
  } run_vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chkp(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_pkg(input int k, input bit row);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < NI; i++) begin
      int e;
      e = k * NI + i;
      if (e < NOE) p[32*(NI-i)-1 -: 32] = row ? m_second[e] : m_first[e];
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = addr[AW-1:0];
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    if (addr < NOE) begin
      if (sel) m_second[addr] = d;
      else     m_first[addr]  = d;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_done"}, bus.done, 1'b0);
    chk1({tag, "_dp_reset"}, bus.dp_reset, 1'b0);
    chk1({tag, "_read_now"}, bus.read_now, 1'b0);
    chk1({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
    chk32({tag, "_result"}, bus.result, 32'h0);
    chkp({tag, "_first_pkg"}, bus.first_row_output, '0);
    chkp({tag, "_second_pkg"}, bus.second_row_output, '0);
  endtask

  task automatic run(input run_vec_t v);
    int d;
    d = v.exp_to ? TMO - 1 : v.fin_at;
    bus.dp_result = v.dres;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk1("clear_dp_reset", bus.dp_reset, 1'b1);
    chk1("clear_busy", bus.busy, 1'b1);
    chk1("clear_read_now", bus.read_now, 1'b0);
    chk1("clear_timeout_err", bus.timeout_err, 1'b0);
    for (int c = 0; c < 2 * P; c++) begin
      if (v.early) bus.dp_finish = 1'b1;
      step();
      chk1("send_read_now", bus.read_now, 1'b1);
      chk1("send_dp_reset", bus.dp_reset, 1'b0);
      chkp("send_first_pkg", bus.first_row_output, exp_pkg(c / 2, 1'b0));
      chkp("send_second_pkg", bus.second_row_output, exp_pkg(c / 2, 1'b1));
    end
    bus.dp_finish = 1'b0;
    for (int w = 0; w <= d; w++) begin
      step();
      chk1("wait_busy", bus.busy, 1'b1);
      chk1("wait_done", bus.done, 1'b0);
      chk1("wait_read_now", bus.read_now, 1'b0);
      chkp("wait_first_pkg", bus.first_row_output, '0);
      if (v.poke && w == 1) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = ~m_first[0];
      end
      if (v.poke && w == 2) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      if (w == v.fin_at) bus.dp_finish = 1'b1;
    end
    step();
    chk1("done_pulse", bus.done, 1'b1);
    chk1("done_busy", bus.busy, 1'b1);
    chk32("done_result", bus.result, v.exp_res);
    chk1("done_timeout_err", bus.timeout_err, v.exp_to);
    bus.dp_finish = 1'b0;
    step();
    chk1("idle_done_low", bus.done, 1'b0);
    chk1("idle_busy", bus.busy, 1'b0);
    chk32("idle_result_held", bus.result, v.exp_res);
    chk1("idle_timeout_sticky", bus.timeout_err, v.exp_to);
  endtask

  run_vec_t tbl [5];

  initial begin
    run_vec_t rv;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.dp_finish = 1'b0; bus.dp_result = '0;
    reset = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    tbl[0] = '{3,       32'h41200000, 1'b0, 1'b0, 32'h41200000, 1'b0};
    tbl[1] = '{0,       32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{-1,      32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b1};
    tbl[3] = '{TMO - 1, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{-1,      32'h55555555, 1'b1, 1'b1, 32'h00000000, 1'b1};

    for (int i = 0; i < NOE; i++) begin
      wr(1'b0, i, 32'h3F800000);
      wr(1'b1, i, 32'h3F800000);
    end
    for (int t = 0; t < 5; t++) run(tbl[t]);

    // Out-of-range writes must leave padding at zero; the busy-time write above must not have landed.
    wr(1'b0, 12, 32'hFFFFFFFF);
    wr(1'b1, 255, 32'hAAAAAAAA);
    run(tbl[1]);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk32("pkg0_msb_cycle0", bus.first_row_output[PW-1 -: 32], 32'h3F800000);
    step();
    chk32("pkg0_msb_cycle1", bus.first_row_output[PW-1 -: 32], 32'h3F800000);
    step();
    chk1("pkg1_read_now", bus.read_now, 1'b1);
    chkp("pkg1_pad_lanes", {{(PW-192){1'b0}}, bus.first_row_output[191:0]}, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("abort");
    for (int c = 0; c < 4; c++) begin
      step();
      chk1("abort_no_done", bus.done, 1'b0);
      chk1("abort_idle", bus.busy, 1'b0);
    end
    run(tbl[0]);

    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 12; n++) wr(1'(($urandom() & 1)), int'($urandom_range(0, TOTAL + 3)), $urandom());
      rv.fin_at  = (r == 5) ? -1 : int'($urandom_range(0, 9));
      rv.dres    = $urandom();
      rv.early   = 1'b0;
      rv.poke    = 1'b0;
      rv.exp_to  = (rv.fin_at < 0);
      rv.exp_res = rv.exp_to ? 32'h0 : rv.dres;
      run(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
